// File: rtl/cond_unit.sv
// Condition/flag stage behind the decoder: NZCV register, condition evaluation,
// write-enable gating and saturating executed/squashed debug counters.
module cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);
  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    pass = 1'b0;
    unique case (cond)
      4'b0000: pass = z;
      4'b0001: pass = ~z;
      4'b0010: pass = c;
      4'b0011: pass = ~c;
      4'b0100: pass = n;
      4'b0101: pass = ~n;
      4'b0110: pass = v;
      4'b0111: pass = ~v;
      4'b1000: pass = c & ~z;
      4'b1001: pass = ~c | z;
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = ~z & (n == v);
      4'b1101: pass = z | (n != v);
      4'b1110: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
endmodule

module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  // Clear beats increment; the counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic             pcs,
  input  logic             regW,
  input  logic             memW,
  input  logic             flagW,
  input  logic             cnt_clr,
  output logic             pcsrc_g,
  output logic             regW_g,
  output logic             memW_g,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] squash_cnt
);
  localparam int NCNT = 2;

  logic [3:0] flags_q, flags_d;
  logic       fire;

  // Evaluated against the registered flags so a CMP affects only later instructions.
  cond_eval u_eval (
    .cond  (cond),
    .flags (flags_q),
    .pass  (cond_ex)
  );

  assign fire    = en & cond_ex;
  assign pcsrc_g = pcs  & fire;
  assign regW_g  = regW & fire;
  assign memW_g  = memW & fire;

  always_comb begin
    flags_d = flags_q;
    if (fire && flagW)
      flags_d = alu_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) flags_q <= 4'b0000;
    else        flags_q <= flags_d;
  end

  assign flags = flags_q;

  // Slot 0 counts executed instructions, slot 1 squashed ones.
  logic [NCNT-1:0]            cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc[0] = en &  cond_ex;
  assign cnt_inc[1] = en & ~cond_ex;

  for (genvar i = 0; i < NCNT; i++) begin : g_cnt
    sat_cnt #(.W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc[i]),
      .cnt   (cnt_val[i])
    );
  end

  assign exec_cnt   = cnt_val[0];
  assign squash_cnt = cnt_val[1];
endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of flags and counters.
module tb_cond_unit;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, en, pcs, regW, memW, flagW, cnt_clr;
  logic [3:0]    cond, alu_flags;
  logic          pcsrc_g, regW_g, memW_g, cond_ex;
  logic [3:0]    flags;
  logic [CW-1:0] exec_cnt, squash_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [3:0] m_flags = 4'b0000;
  int         m_exec  = 0;
  int         m_squash = 0;

  always #5 clk = ~clk;

  cond_unit #(.CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cond       (cond),
    .alu_flags  (alu_flags),
    .pcs        (pcs),
    .regW       (regW),
    .memW       (memW),
    .flagW      (flagW),
    .cnt_clr    (cnt_clr),
    .pcsrc_g    (pcsrc_g),
    .regW_g     (regW_g),
    .memW_g     (memW_g),
    .cond_ex    (cond_ex),
    .flags      (flags),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  function automatic logic cp(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Advance one clock, stepping the model with the inputs held over the edge.
  task automatic cycle();
    logic [3:0] nf;
    int ne, ns;
    bit p;
    p = cp(cond, m_flags);
    nf = m_flags; ne = m_exec; ns = m_squash;
    if (!rst_n) begin
      nf = 4'b0000; ne = 0; ns = 0;
    end else begin
      if (en && flagW && p) nf = alu_flags;
      if (cnt_clr) begin
        ne = 0; ns = 0;
      end else if (en) begin
        if (p) ne = (m_exec == MAX) ? MAX : m_exec + 1;
        else   ns = (m_squash == MAX) ? MAX : m_squash + 1;
      end
    end
    @(posedge clk);
    #1;
    m_flags = nf; m_exec = ne; m_squash = ns;
  endtask

  task automatic idle_inputs();
    en = 0; pcs = 0; regW = 0; memW = 0; flagW = 0; cnt_clr = 0;
    cond = 4'hE; alu_flags = 4'h0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    cycle(); cycle();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
    checks++; if (exec_cnt !== '0) begin failures++; $display("FAIL reset_exec got=%0d exp=0", exec_cnt); end
    checks++; if (squash_cnt !== '0) begin failures++; $display("FAIL reset_squash got=%0d exp=0", squash_cnt); end
    rst_n = 1; cond = 4'b0000; #1;
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL reset_eq got=%b exp=0", cond_ex); end
    cond = 4'b0001; #1;
    checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL reset_ne got=%b exp=1", cond_ex); end
    cond = 4'b1110; #1;
    checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL reset_al got=%b exp=1", cond_ex); end
  endtask

  task automatic test_cmp_beq();
    en = 1; flagW = 1; cond = 4'b1110; alu_flags = 4'b0100;
    cycle();
    checks++; if (flags !== 4'b0100) begin failures++; $display("FAIL cmp_flags got=%b exp=0100", flags); end
    flagW = 0; cond = 4'b0000; pcs = 1; alu_flags = 4'b0000; #1;
    checks++; if (pcsrc_g !== 1'b1) begin failures++; $display("FAIL beq_pcsrc got=%b exp=1", pcsrc_g); end
    cycle();
    checks++; if (exec_cnt !== CW'(2)) begin failures++; $display("FAIL beq_exec got=%0d exp=2", exec_cnt); end
    pcs = 0;
  endtask

  task automatic test_squash();
    int sq0;
    en = 1; flagW = 1; cond = 4'b1110; alu_flags = 4'b0000;
    cycle();
    flagW = 0; cond = 4'b0000; regW = 1; memW = 1; #1;
    checks++; if (regW_g !== 1'b0 || memW_g !== 1'b0) begin failures++; $display("FAIL squash_gate got=%b%b exp=00", regW_g, memW_g); end
    sq0 = int'(squash_cnt);
    cycle();
    checks++; if (int'(squash_cnt) !== sq0 + 1) begin failures++; $display("FAIL squash_cnt got=%0d exp=%0d", squash_cnt, sq0 + 1); end
    regW = 0; memW = 0; flagW = 1; alu_flags = 4'b1111;
    cycle();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL squash_flags got=%b exp=0000", flags); end
    flagW = 0;
  endtask

  task automatic test_cond_sweep();
    for (int f = 0; f < 16; f++) begin
      en = 1; flagW = 1; cond = 4'b1110; alu_flags = 4'(f);
      cycle();
      en = 0; flagW = 0;
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c); #1;
        checks++;
        if (cond_ex !== cp(4'(c), 4'(f))) begin
          failures++; $display("FAIL sweep f=%b c=%b got=%b exp=%b", 4'(f), 4'(c), cond_ex, cp(4'(c), 4'(f)));
        end
      end
    end
    en = 1; flagW = 1; cond = 4'b1110; alu_flags = 4'b1000;
    cycle();
    en = 0; flagW = 0;
    cond = 4'b1011; #1;
    checks++; if (cond_ex !== 1'b1) begin failures++; $display("FAIL sweep_lt got=%b exp=1", cond_ex); end
    cond = 4'b1010; #1;
    checks++; if (cond_ex !== 1'b0) begin failures++; $display("FAIL sweep_ge got=%b exp=0", cond_ex); end
  endtask

  task automatic test_saturation();
    en = 0; cnt_clr = 1; cycle(); cnt_clr = 0;
    en = 1; cond = 4'b1110;
    for (int i = 0; i < 20; i++) cycle();
    checks++; if (exec_cnt !== CW'(MAX)) begin failures++; $display("FAIL sat_exec got=%0d exp=%0d", exec_cnt, MAX); end
    checks++; if (squash_cnt !== '0) begin failures++; $display("FAIL sat_squash got=%0d exp=0", squash_cnt); end
    cnt_clr = 1; cycle(); cnt_clr = 0;
    checks++; if (exec_cnt !== '0) begin failures++; $display("FAIL clr_exec got=%0d exp=0", exec_cnt); end
    en = 0;
  endtask

  task automatic test_stall_reset();
    logic [3:0] f0;
    f0 = flags;
    en = 0; flagW = 1; pcs = 1; regW = 1; memW = 1; cond = 4'b1110; alu_flags = ~f0; #1;
    checks++; if ({pcsrc_g, regW_g, memW_g} !== 3'b000) begin failures++; $display("FAIL stall_gate got=%b exp=000", {pcsrc_g, regW_g, memW_g}); end
    cycle();
    checks++; if (flags !== f0) begin failures++; $display("FAIL stall_flags got=%b exp=%b", flags, f0); end
    en = 1; alu_flags = 4'b0110; cycle();
    rst_n = 0; alu_flags = 4'b1111; #1;
    checks++; if (regW_g !== 1'b1) begin failures++; $display("FAIL rst_gate got=%b exp=1", regW_g); end
    cycle();
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL rst_flags got=%b exp=0000", flags); end
    checks++; if (exec_cnt !== '0 || squash_cnt !== '0) begin failures++; $display("FAIL rst_cnt got=%0d/%0d exp=0/0", exec_cnt, squash_cnt); end
    rst_n = 1; idle_inputs();
  endtask

  task automatic test_random();
    bit p;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(31) != 0);
      en = ($urandom_range(7) != 0);
      cond = 4'($urandom_range(15));
      alu_flags = 4'($urandom_range(15));
      pcs = 1'($urandom); regW = 1'($urandom); memW = 1'($urandom);
      flagW = ($urandom_range(2) == 0);
      cnt_clr = ($urandom_range(15) == 0);
      #1;
      p = cp(cond, m_flags);
      checks++; if (cond_ex !== p) begin failures++; $display("FAIL rnd_cond i=%0d got=%b exp=%b", i, cond_ex, p); end
      checks++;
      if ({pcsrc_g, regW_g, memW_g} !== {pcs & p & en, regW & p & en, memW & p & en}) begin
        failures++; $display("FAIL rnd_gate i=%0d got=%b exp=%b", i, {pcsrc_g, regW_g, memW_g}, {pcs & p & en, regW & p & en, memW & p & en});
      end
      cycle();
      checks++; if (flags !== m_flags) begin failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, flags, m_flags); end
      checks++; if (int'(exec_cnt) !== m_exec) begin failures++; $display("FAIL rnd_exec i=%0d got=%0d exp=%0d", i, exec_cnt, m_exec); end
      checks++; if (int'(squash_cnt) !== m_squash) begin failures++; $display("FAIL rnd_squash i=%0d got=%0d exp=%0d", i, squash_cnt, m_squash); end
    end
    rst_n = 1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cmp_beq();
    test_squash();
    test_cond_sweep();
    test_saturation();
    test_stall_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
